fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h8000_0000, PC fetched first after reset.
REQ-002 SHALL have parameter IMEM_ADDR_WIDTH, 32, width of imem_req_addr.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 flush  input  1  backend redirect; same signal drives the instruction buffer flush.
REQ-006 redirect_pc  input  32  new fetch PC, valid when flush=1.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  IMEM_ADDR_WIDTH  word-aligned fetch address.
REQ-010 imem_resp_valid  input  1  instruction word returned.
REQ-011 imem_resp_data  input  32  instruction word.
REQ-012 ins_full  input  1  instruction buffer full.
REQ-013 wr_en  output  1  push to instruction buffer.
REQ-014 pc_out  output  32  PC of pushed instruction.
REQ-015 next_pc_out  output  32  pc_out+4, mod 2^32.
REQ-016 instruction_out  output  32  pushed instruction word.
REQ-017 fetch_count  output  32  count of pushed instructions.

Function
REQ-018 SHALL keep at most one imem request outstanding.
REQ-019 SHALL implement FSM states REQ, WAIT, HOLD, DRAIN.
REQ-020 REQ: imem_req_valid=1, imem_req_addr=pc; req_valid&req_ready -> WAIT; otherwise stay.
REQ-021 WAIT: resp_valid&!ins_full -> wr_en=1 same cycle with resp data, pc<=pc+4, -> REQ.
REQ-022 WAIT: resp_valid&ins_full -> capture pc/data into hold register, -> HOLD; wr_en=0.
REQ-023 HOLD: wr_en=1 from hold register when !ins_full, then pc<=pc+4, -> REQ; stay while ins_full.
REQ-024 DRAIN: wr_en=0; resp_valid discarded, -> REQ; stay otherwise.
REQ-025 flush SHALL take priority over all transitions; wr_en=0 in any cycle with flush=1.
REQ-026 flush: pc<={redirect_pc[31:2],2'b00}; hold register invalidated.
REQ-027 flush in REQ with req handshake same cycle -> DRAIN; REQ without handshake -> REQ.
REQ-028 flush in WAIT without resp_valid -> DRAIN; with resp_valid same cycle -> response dropped, -> REQ.
REQ-029 flush in HOLD or DRAIN (resp_valid or not) -> REQ; a resp arriving in DRAIN with flush is consumed.
REQ-030 imem_req_valid SHALL be 0 outside REQ and in any cycle with flush=1.
REQ-031 pc+4 and next_pc_out SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-032 fetch_count SHALL increment by 1 per cycle with wr_en=1, wrap at 2^32, unaffected by flush.
REQ-033 pc_out/instruction_out/next_pc_out SHALL be 0 when wr_en=0.

Reset
REQ-034 reset=0 at a clock edge: state<=REQ, pc<=RESET_PC, hold invalid, fetch_count<=0.
REQ-035 During reset all outputs SHALL be 0; first request with addr=RESET_PC in first cycle after reset=1.
REQ-036 Reset mid-WAIT/DRAIN: outstanding response arriving after reset is discarded by the memory side; no DRAIN tracking across reset.

Structure
REQ-037 Shared package SHALL hold the fetch FSM state enum and RESET_PC default constant.
REQ-038 No sub-module; single module with one FSM, pc register, hold register, counter.

Verification
REQ-039 Reset release, ready=1, resp 1 cycle later, ins_full=0 -> wr_en pc_out=8000_0000, next_pc_out=8000_0004, next req addr 8000_0004.
REQ-040 ins_full=1 for 3 cycles on resp -> HOLD, wr_en=0; ins_full drops -> single push with held data, fetch_count+1.
REQ-041 flush redirect_pc=0000_0102 while WAIT -> DRAIN; stale resp dropped (wr_en=0); next req addr 0000_0100.
REQ-042 flush same cycle as resp_valid in WAIT -> wr_en=0, next req addr=redirect_pc, no DRAIN.
REQ-043 Sequential fetch from FFFF_FFFC -> next_pc_out=0, next req addr 0.
REQ-044 imem_req_ready=0 for 5 cycles -> req_valid and addr held stable, no pushes.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// the default boot PC.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit: issues word fetches,
// pushes returned words into the instruction buffer and handles redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          IMEM_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [31:0]                redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [31:0]                imem_resp_data,
  input  logic                       ins_full,
  output logic                       wr_en,
  output logic [31:0]                pc_out,
  output logic [31:0]                next_pc_out,
  output logic [31:0]                instruction_out,
  output logic [31:0]                fetch_count
);

  fetch_state_e r_state;
  fetch_state_e w_nextState;
  logic [31:0]  r_pc;
  logic [31:0]  r_holdPc;
  logic [31:0]  r_holdData;
  logic         r_holdValid;
  logic [31:0]  r_fetchCount;

  logic         w_reqValid;
  logic         w_handshake;
  logic         w_wrEn;
  logic [31:0]  w_pushPc;
  logic [31:0]  w_pushData;
  logic [31:0]  w_pcNext;
  logic         w_captureHold;
  logic         w_releaseHold;

  assign w_handshake = w_reqValid & imem_req_ready;

  // Flush overrides every transition and suppresses both request and push.
  always_comb begin
    w_nextState   = r_state;
    w_reqValid    = 1'b0;
    w_wrEn        = 1'b0;
    w_pushPc      = 32'd0;
    w_pushData    = 32'd0;
    w_pcNext      = r_pc;
    w_captureHold = 1'b0;
    w_releaseHold = 1'b0;
    if (reset) begin
      case (r_state)
        S_REQ: begin
          w_reqValid = !flush;
          if (flush)
            w_nextState = w_handshake ? S_DRAIN : S_REQ;
          else if (w_handshake)
            w_nextState = S_WAIT;
        end
        S_WAIT: begin
          if (flush) begin
            w_nextState = imem_resp_valid ? S_REQ : S_DRAIN;
          end else if (imem_resp_valid && !ins_full) begin
            w_wrEn      = 1'b1;
            w_pushPc    = r_pc;
            w_pushData  = imem_resp_data;
            w_pcNext    = pcPlus4(r_pc);
            w_nextState = S_REQ;
          end else if (imem_resp_valid) begin
            w_captureHold = 1'b1;
            w_nextState   = S_HOLD;
          end
        end
        S_HOLD: begin
          if (flush) begin
            w_nextState = S_REQ;
          end else if (!ins_full && r_holdValid) begin
            w_wrEn        = 1'b1;
            w_pushPc      = r_holdPc;
            w_pushData    = r_holdData;
            w_pcNext      = pcPlus4(r_pc);
            w_releaseHold = 1'b1;
            w_nextState   = S_REQ;
          end
        end
        S_DRAIN: begin
          if (flush || imem_resp_valid)
            w_nextState = S_REQ;
        end
        default: w_nextState = S_REQ;
      endcase
      if (flush)
        w_pcNext = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_holdValid  <= 1'b0;
      r_holdPc     <= 32'd0;
      r_holdData   <= 32'd0;
      r_fetchCount <= 32'd0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_pcNext;
      if (w_wrEn)
        r_fetchCount <= r_fetchCount + 32'd1;
      if (flush || w_releaseHold) begin
        r_holdValid <= 1'b0;
      end else if (w_captureHold) begin
        r_holdValid <= 1'b1;
        r_holdPc    <= r_pc;
        r_holdData  <= imem_resp_data;
      end
    end
  end

  // All outputs read as zero while reset is asserted.
  assign imem_req_valid  = w_reqValid;
  assign imem_req_addr   = reset ? IMEM_ADDR_WIDTH'(r_pc) : '0;
  assign wr_en           = w_wrEn;
  assign pc_out          = w_pushPc;
  assign instruction_out = w_pushData;
  assign next_pc_out     = w_wrEn ? pcPlus4(w_pushPc) : 32'd0;
  assign fetch_count     = reset ? r_fetchCount : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: each cycle drives inputs after
// the falling edge and checks the combinational outputs before the rising edge.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        ins_full;
  logic        wr_en;
  logic [31:0] pc_out;
  logic [31:0] next_pc_out;
  logic [31:0] instruction_out;
  logic [31:0] fetch_count;

  int checkCount;
  int errorCount;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .ins_full        (ins_full),
    .wr_en           (wr_en),
    .pc_out          (pc_out),
    .next_pc_out     (next_pc_out),
    .instruction_out (instruction_out),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs just after the falling edge, then lets outputs settle.
  task automatic applyStimulus(input logic rst, input logic fl, input logic [31:0] rpc,
                               input logic rdy, input logic rv, input logic [31:0] rdata,
                               input logic full);
    @(negedge clk);
    reset           = rst;
    flush           = fl;
    redirect_pc     = rpc;
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rdata;
    ins_full        = full;
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b0; flush = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; ins_full = 1'b0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("rst_count", fetch_count, 32'd0);
    checkOutput("rst_addr", imem_req_addr, 32'd0);
    applyStimulus(0, 0, 0, 1, 1, 32'h1111_1111, 0);
    checkOutput("rst_req_valid2", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_instr", instruction_out, 32'd0);

    // First fetch after reset release
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("first_req_addr", imem_req_addr, 32'h8000_0000);
    applyStimulus(1, 0, 0, 0, 1, 32'hDEAD_0001, 0);
    checkOutput("first_wr_en", {31'd0, wr_en}, 32'd1);
    checkOutput("first_pc_out", pc_out, 32'h8000_0000);
    checkOutput("first_next_pc", next_pc_out, 32'h8000_0004);
    checkOutput("first_instr", instruction_out, 32'hDEAD_0001);
    checkOutput("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // Memory not ready for 5 cycles
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      checkOutput("stall_addr", imem_req_addr, 32'h8000_0004);
      checkOutput("stall_wr_en", {31'd0, wr_en}, 32'd0);
      checkOutput("stall_pc_out", pc_out, 32'd0);
      checkOutput("stall_count", fetch_count, 32'd1);
    end
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("req2_addr", imem_req_addr, 32'h8000_0004);

    // Buffer full on response: hold for 3 cycles, then a single push
    applyStimulus(1, 0, 0, 0, 1, 32'hCAFE_0002, 1);
    checkOutput("full_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("full_instr", instruction_out, 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 32'h5555_5555, 1);
      checkOutput("hold_wr_en", {31'd0, wr_en}, 32'd0);
      checkOutput("hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("hold_push_wr_en", {31'd0, wr_en}, 32'd1);
    checkOutput("hold_push_pc", pc_out, 32'h8000_0004);
    checkOutput("hold_push_next", next_pc_out, 32'h8000_0008);
    checkOutput("hold_push_instr", instruction_out, 32'hCAFE_0002);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("hold_count", fetch_count, 32'd2);
    checkOutput("req3_addr", imem_req_addr, 32'h8000_0008);

    // Flush while waiting without response: drain the stale word
    applyStimulus(1, 1, 32'h0000_0102, 0, 0, 0, 0);
    checkOutput("flush_wait_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("flush_wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus(1, 0, 0, 1, 1, 32'hBAD0_BAD0, 0);
    checkOutput("drain_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("drain_req_valid", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("redir_addr", imem_req_addr, 32'h0000_0100);

    // Flush coinciding with the response: dropped, no drain
    applyStimulus(1, 1, 32'hFFFF_FFFE, 0, 1, 32'hBAD1_BAD1, 0);
    checkOutput("flush_resp_wr_en", {31'd0, wr_en}, 32'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    checkOutput("nodrain_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("nodrain_addr", imem_req_addr, 32'hFFFF_FFFC);

    // PC wrap at the top of the address space
    applyStimulus(1, 0, 0, 0, 1, 32'h1234_5678, 0);
    checkOutput("wrap_wr_en", {31'd0, wr_en}, 32'd1);
    checkOutput("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    checkOutput("wrap_next_pc", next_pc_out, 32'h0000_0000);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_addr", imem_req_addr, 32'h0000_0000);
    checkOutput("wrap_count", fetch_count, 32'd3);

    // Flush in HOLD beats the push even when buffer frees up
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 32'h7777_7777, 1);
    checkOutput("hold2_wr_en", {31'd0, wr_en}, 32'd0);
    applyStimulus(1, 1, 32'h0000_0040, 0, 0, 0, 0);
    checkOutput("flush_hold_wr_en", {31'd0, wr_en}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_hold_addr", imem_req_addr, 32'h0000_0040);
    checkOutput("flush_hold_count", fetch_count, 32'd3);

    // Flush in REQ: request suppressed, stays in REQ with new PC
    applyStimulus(1, 1, 32'h0000_0200, 1, 0, 0, 0);
    checkOutput("flush_req_valid", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("flush_req_valid2", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("flush_req_addr", imem_req_addr, 32'h0000_0200);

    // Reset mid-WAIT returns to boot PC and clears the counter
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst2_count", fetch_count, 32'd0);
    checkOutput("rst2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst2_req_valid2", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("rst2_addr", imem_req_addr, 32'h8000_0000);
    checkOutput("rst2_count2", fetch_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
